// File: rtl/mul_8bit_seq.sv
// -----------------------------------------------------------------------------
// mul_8bit_seq
//   Sequential 8x8 unsigned shift-and-add multiplier with a 16-bit product.
//   A single 8-bit ripple-carry adder (adder_8bit) does all the arithmetic.
//   Each RUN cycle adds the multiplicand into the high half when the current
//   multiplier LSB is set, then shifts {carry, sum, multiplier} right by one.
//   The operation takes 8 iterations, then a one-cycle done pulse is produced.
//
// Ports (mul_8bit_seq):
//   clk    in   1   clock, rising edge
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   multiply request, sampled only while idle
//   A      in   8   multiplicand, captured on the accepted start edge
//   B      in   8   multiplier, captured on the accepted start edge
//   busy   out  1   high while an operation is running or completing
//   done   out  1   one-cycle pulse, P valid while high
//   P      out 16   registered product, held until next accepted start/reset
//
// Ports (adder_8bit):
//   A, B   in   8   addends
//   C_in   in   1   carry in
//   S      out  8   sum
//   C_out  out  1   carry out
// -----------------------------------------------------------------------------

module adder_8bit (
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       C_in,
   output logic [7:0] S,
   output logic       C_out
);

   logic [8:0] carry;

   assign carry[0] = C_in;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_fa
         assign S[gi]       = A[gi] ^ B[gi] ^ carry[gi];
         assign carry[gi+1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
      end
   endgenerate

   assign C_out = carry[8];

endmodule

module mul_8bit_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   output logic        busy,
   output logic        done,
   output logic [15:0] P
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [7:0]  m_reg,     m_next;
   logic [7:0]  q_reg,     q_next;
   logic [7:0]  acc_reg,   acc_next;
   logic [3:0]  cnt_reg,   cnt_next;
   logic [15:0] p_reg,     p_next;

   logic [7:0]  add_b;
   logic [7:0]  sum;
   logic        c_out;
   logic [15:0] shifted;

   // Add the multiplicand only when the current multiplier bit is set.
   assign add_b = q_reg[0] ? m_reg : 8'h00;

   adder_8bit u_adder (
      .A     (acc_reg),
      .B     (add_b),
      .C_in  (1'b0),
      .S     (sum),
      .C_out (c_out)
   );

   // The 9-bit {carry, sum} cannot overflow (ACC + M <= 0x1FE), so the carry
   // simply becomes the new MSB of the product after the right shift.
   assign shifted = {c_out, sum, q_reg[7:1]};

   always_comb begin
      state_next = state_reg;
      m_next     = m_reg;
      q_next     = q_reg;
      acc_next   = acc_reg;
      cnt_next   = cnt_reg;
      p_next     = p_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               m_next     = A;
               q_next     = B;
               acc_next   = 8'h00;
               cnt_next   = 4'd0;
               state_next = RUN;
            end
         end
         RUN: begin
            acc_next = shifted[15:8];
            q_next   = shifted[7:0];
            cnt_next = cnt_reg + 4'd1;
            if (cnt_reg == 4'd7) begin
               p_next     = shifted;
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         m_reg     <= 8'h00;
         q_reg     <= 8'h00;
         acc_reg   <= 8'h00;
         cnt_reg   <= 4'd0;
         p_reg     <= 16'h0000;
      end else begin
         state_reg <= state_next;
         m_reg     <= m_next;
         q_reg     <= q_next;
         acc_reg   <= acc_next;
         cnt_reg   <= cnt_next;
         p_reg     <= p_next;
      end
   end

   // Outputs come from registered state only.
   assign busy = (state_reg != IDLE);
   assign done = (state_reg == DONE);
   assign P    = p_reg;

endmodule

// File: tb/tb_mul_8bit_seq.sv
// -----------------------------------------------------------------------------
// tb_mul_8bit_seq
//   Directed-vector bench for mul_8bit_seq. Expected products are hand-computed
//   constants; cycle timing of busy/done is checked on every clock.
// -----------------------------------------------------------------------------

module tb_mul_8bit_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  A;
   logic [7:0]  B;
   logic        busy;
   logic        done;
   logic [15:0] P;

   int n_vec;
   int n_miss;

   mul_8bit_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .P     (P)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
      end
   endtask

   // One complete operation. With poke set, start is re-pulsed with 9x9 during
   // RUN and during DONE; both pulses must be ignored.
   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input bit poke);
      @(negedge clk);
      A = a; B = b; start = 1'b1;
      @(posedge clk); #1;                       // E0
      start = 1'b0;
      A = 8'($urandom); B = 8'($urandom);       // must not disturb the operation
      check_eq({tag, "_busy_e0"}, {15'd0, busy}, 16'd1);
      check_eq({tag, "_done_e0"}, {15'd0, done}, 16'd0);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (poke && i == 3) begin
            start = 1'b1; A = 8'd9; B = 8'd9;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;                    // Ei
         check_eq($sformatf("%s_busy_e%0d", tag, i), {15'd0, busy}, 16'd1);
         check_eq($sformatf("%s_done_e%0d", tag, i), {15'd0, done}, (i == 8) ? 16'd1 : 16'd0);
      end
      check_eq({tag, "_P"}, P, exp);
      @(negedge clk);
      if (poke) begin
         start = 1'b1; A = 8'd9; B = 8'd9;      // start seen while in DONE
      end
      @(posedge clk); #1;                       // E9
      check_eq({tag, "_busy_e9"}, {15'd0, busy}, 16'd0);
      check_eq({tag, "_done_e9"}, {15'd0, done}, 16'd0);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;                       // E10: nothing remembered
      check_eq({tag, "_busy_e10"}, {15'd0, busy}, 16'd0);
      check_eq({tag, "_P_hold"}, P, exp);
      $display("op %s: %0d x %0d -> P=0x%04h (expect 0x%04h)", tag, a, b, P, exp);
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      A      = 8'h00;
      B      = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", {15'd0, busy}, 16'd0);
      check_eq("rst_done", {15'd0, done}, 16'd0);
      check_eq("rst_P", P, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("13x11",  8'd13,  8'd11,  16'h008F, 1'b0);
      run_op("FFxFF",  8'hFF,  8'hFF,  16'hFE01, 1'b0);
      run_op("80x02",  8'h80,  8'h02,  16'h0100, 1'b0);
      run_op("00xFF",  8'h00,  8'hFF,  16'h0000, 1'b0);
      run_op("FFx00",  8'hFF,  8'h00,  16'h0000, 1'b0);
      run_op("3x5ign", 8'd3,   8'd5,   16'h000F, 1'b1);

      // Abort mid-RUN with reset; P must clear even though it held 0x000F.
      @(negedge clk);
      A = 8'hAA; B = 8'h55; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("abort_busy", {15'd0, busy}, 16'd0);
      check_eq("abort_done", {15'd0, done}, 16'd0);
      check_eq("abort_P", P, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int seen_done;
         seen_done = 0;
         for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) seen_done++;
         end
         check_eq("abort_no_done", 16'(seen_done), 16'd0);
      end
      $display("op abort: reset mid-RUN, P=0x%04h", P);
      run_op("2x3", 8'd2, 8'd3, 16'h0006, 1'b0);

      // start held high: accepted every 10 cycles, done at offsets 8, 18, 28.
      @(negedge clk);
      A = 8'h10; B = 8'h10; start = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         check_eq($sformatf("b2b_done_k%0d", k), {15'd0, done},
                  ((k % 10) == 8) ? 16'd1 : 16'd0);
         check_eq($sformatf("b2b_P_k%0d", k), P, (k < 8) ? 16'h0006 : 16'h0100);
         if (done) $display("op b2b: done at k=%0d P=0x%04h", k, P);
      end
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
